// File: rtl/icache_line_refill.sv
// icache_line_refill: fetches one cache line from next-level memory as a
// burst of narrow beats, assembles it into a line-wide buffer and writes it
// into the dual-port line memory with a single one-cycle strobe.
//
// Handshakes:
//   miss side   : a miss is taken on a cycle where miss_valid && miss_ready.
//                 miss_ready is high only in IDLE.
//   request side: mem_req_valid stays high and mem_req_address stays stable
//                 until the cycle where mem_req_valid && mem_req_ready.
//   response    : mem_resp_valid has no back-pressure. Each valid cycle in
//                 FILL is one beat. Beats outside FILL are dropped.
module icache_line_refill #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int WORD_WIDTH    = 32,
    parameter int LINE_WIDTH    = 512,
    parameter int MEMORY_DEPTH  = 512,
    localparam int BEATS        = LINE_WIDTH / WORD_WIDTH,
    localparam int OFFSET_BITS  = $clog2(LINE_WIDTH / 8),
    localparam int INDEX_BITS   = $clog2(MEMORY_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  logic [ADDRESS_WIDTH-1:0] miss_address,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_req_address,
    input  logic                     mem_resp_valid,
    input  logic [WORD_WIDTH-1:0]    mem_resp_data,
    output logic [INDEX_BITS-1:0]    write_address,
    output logic [LINE_WIDTH-1:0]    line_data,
    output logic                     write_enable,
    output logic                     refill_done,
    output logic                     busy,
    output logic [2:0]               state_dbg
);

    localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = {ADDRESS_WIDTH{1'b1}} << OFFSET_BITS;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQUEST = 3'd1,
        S_FILL    = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BEAT_BITS-1:0] beat_cnt;
    logic                 last_beat;

    assign last_beat     = (beat_cnt == LAST_BEAT);

    assign miss_ready    = (state == S_IDLE);
    assign mem_req_valid = (state == S_REQUEST);
    assign write_enable  = (state == S_WRITE);
    assign refill_done   = (state == S_DONE);
    assign busy          = (state != S_IDLE);
    assign state_dbg     = state;

    // State register; reset drops any partial refill back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one pass through request, fill, write, done.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (miss_valid)                  state_next = S_REQUEST;
            S_REQUEST: if (mem_req_ready)               state_next = S_FILL;
            S_FILL:    if (mem_resp_valid && last_beat) state_next = S_WRITE;
            S_WRITE:                                    state_next = S_DONE;
            S_DONE:                                     state_next = S_IDLE;
            default:                                    state_next = S_IDLE;
        endcase
    end

    // Datapath: latch addresses on miss, count beats, assemble the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt        <= '0;
            line_data       <= '0;
            mem_req_address <= '0;
            write_address   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_valid) begin
                        // Masking only: no carry into the tag bits, and the
                        // index simply drops everything above the line memory.
                        mem_req_address <= miss_address & LINE_MASK;
                        write_address   <= miss_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
                    end
                end
                S_REQUEST: begin
                    if (mem_req_ready) begin
                        beat_cnt <= '0;
                    end
                end
                S_FILL: begin
                    if (mem_resp_valid) begin
                        // Beat k lands in word k, beat 0 least significant.
                        for (int i = 0; i < BEATS; i++) begin
                            if (beat_cnt == BEAT_BITS'(i)) begin
                                line_data[i*WORD_WIDTH +: WORD_WIDTH] <= mem_resp_data;
                            end
                        end
                        // Counter returns to 0 after the last beat so it never
                        // leaves the range 0..BEATS-1.
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_line_refill.sv
// Self-checking bench for icache_line_refill: a table of directed refills,
// hand-written reset-abort and back-to-back sequences, then randomized
// refills checked against an address/latency/line model and a write queue.
module tb_icache_line_refill;

    localparam int AW         = 32;
    localparam int WW         = 32;
    localparam int LW         = 512;
    localparam int DEPTH      = 512;
    localparam int BEATS      = LW / WW;
    localparam int IB         = 9;
    localparam int LINE_BYTES = LW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          miss_valid;
    logic          miss_ready;
    logic [AW-1:0] miss_address;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_address;
    logic          mem_resp_valid;
    logic [WW-1:0] mem_resp_data;
    logic [IB-1:0] write_address;
    logic [LW-1:0] line_data;
    logic          write_enable;
    logic          refill_done;
    logic          busy;
    logic [2:0]    state_dbg;

    logic [IB+LW-1:0] exp_q[$];
    int n_cmp     = 0;
    int n_bad     = 0;
    int cyc       = 0;
    int we_pulses = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            stall;
        int            gap_mode;
        logic [WW-1:0] base;
        bit            stray;
        logic [AW-1:0] exp_req;
        logic [IB-1:0] exp_idx;
        int            exp_lat;
    } vec_t;

    vec_t vecs[5];

    icache_line_refill dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .miss_valid      (miss_valid),
        .miss_ready      (miss_ready),
        .miss_address    (miss_address),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_address (mem_req_address),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .write_address   (write_address),
        .line_data       (line_data),
        .write_enable    (write_enable),
        .refill_done     (refill_done),
        .busy            (busy),
        .state_dbg       (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: line address and index from plain arithmetic.
    function automatic logic [AW-1:0] model_req(input logic [AW-1:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic logic [IB-1:0] model_idx(input logic [AW-1:0] a);
        return IB'((a / LINE_BYTES) % DEPTH);
    endfunction

    // Scoreboard: every write strobe must match the oldest expected line.
    always @(negedge clk) begin
        logic [IB+LW-1:0] e;
        if (rst_n && write_enable) begin
            we_pulses++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: index %0h with no expected line", write_address);
            end else begin
                e = exp_q.pop_front();
                chk("write_index", LW'(write_address), LW'(e[LW+IB-1:LW]));
                chk("line_data", line_data, e[LW-1:0]);
            end
        end
    end

    // Driver: one complete refill, or an aborted one when abort_after >= 0.
    task automatic do_refill(input logic [AW-1:0] addr, input int stall, input int gap_mode,
                             input logic [WW-1:0] base, input bit stray, input bit hold,
                             input logic [AW-1:0] hold_addr, input int abort_after,
                             input logic [AW-1:0] exp_req, input logic [IB-1:0] exp_idx,
                             input int exp_lat, output int t0, output int t_done);
        logic [LW-1:0] line;
        int n;
        int k;
        int g;
        int lat;
        int we_before;
        bit v;
        for (int i = 0; i < BEATS; i++) line[i*WW +: WW] = base + WW'(i);
        n = 0;
        while (!miss_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", LW'(miss_ready), LW'(1));
        if (abort_after < 0) exp_q.push_back({exp_idx, line});
        miss_valid   = 1'b1;
        miss_address = addr;
        t0           = cyc;
        mem_resp_valid = stray;
        mem_resp_data  = $urandom;
        @(negedge clk);
        miss_valid   = hold;
        miss_address = hold ? hold_addr : $urandom;
        chk("req_valid", LW'(mem_req_valid), LW'(1));
        chk("req_address", LW'(mem_req_address), LW'(exp_req));
        chk("miss_ready_busy", LW'(miss_ready), LW'(0));
        mem_req_ready  = (stall == 0);
        mem_resp_valid = stray;
        mem_resp_data  = $urandom;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("req_hold_valid", LW'(mem_req_valid), LW'(1));
            chk("req_hold_address", LW'(mem_req_address), LW'(exp_req));
            if (s == stall - 1) mem_req_ready = 1'b1;
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("req_dropped", LW'(mem_req_valid), LW'(0));
        k = 0;
        g = 0;
        while (k < BEATS) begin
            if (abort_after >= 0 && k == abort_after) break;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (g % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            mem_resp_valid = v;
            mem_resp_data  = v ? line[k*WW +: WW] : WW'($urandom);
            if (v) k++;
            g++;
            @(negedge clk);
            if (k < BEATS) chk("no_early_write", LW'(write_enable), LW'(0));
        end
        mem_resp_valid = 1'b0;
        if (abort_after >= 0) begin
            we_before = we_pulses;
            #2 rst_n = 1'b0;
            #1;
            chk("rst_mid_miss_ready", LW'(miss_ready), LW'(1));
            chk("rst_mid_busy", LW'(busy), LW'(0));
            chk("rst_mid_req_valid", LW'(mem_req_valid), LW'(0));
            chk("rst_mid_req_address", LW'(mem_req_address), LW'(0));
            chk("rst_mid_write_address", LW'(write_address), LW'(0));
            chk("rst_mid_line_data", line_data, LW'(0));
            chk("rst_mid_write_enable", LW'(write_enable), LW'(0));
            chk("rst_mid_state", LW'(state_dbg), LW'(0));
            @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            chk("rst_mid_no_write", LW'(we_pulses), LW'(we_before));
            t_done = cyc;
            return;
        end
        lat = cyc - t0;
        chk("write_enable", LW'(write_enable), LW'(1));
        chk("write_latency", LW'(lat), LW'((exp_lat >= 0) ? exp_lat : 2 + stall + g));
        chk("done_early", LW'(refill_done), LW'(0));
        @(negedge clk);
        chk("refill_done", LW'(refill_done), LW'(1));
        chk("we_single", LW'(write_enable), LW'(0));
        chk("miss_ready_done", LW'(miss_ready), LW'(0));
        t_done = cyc;
        @(negedge clk);
        chk("back_idle", LW'(miss_ready), LW'(1));
        chk("idle_not_busy", LW'(busy), LW'(0));
        chk("done_single", LW'(refill_done), LW'(0));
    endtask

    initial begin
        int t0a;
        int tda;
        int t0b;
        int tdb;
        logic [AW-1:0] a;
        int st;

        vecs[0] = '{32'h0000_1234, 0, 0, 32'hA000_0000, 1'b0, 32'h0000_1200, 9'h048, 18};
        vecs[1] = '{32'h0000_2000, 5, 0, 32'h1111_0000, 1'b1, 32'h0000_2000, 9'h080, 23};
        vecs[2] = '{32'h0000_ABCD, 0, 1, 32'h5555_0100, 1'b0, 32'h0000_ABC0, 9'h0AF, 33};
        vecs[3] = '{32'hFFFF_FFFF, 0, 0, 32'hDEAD_0000, 1'b1, 32'hFFFF_FFC0, 9'h1FF, 18};
        vecs[4] = '{32'h8000_0FC0, 2, 0, 32'h0BAD_F000, 1'b0, 32'h8000_0FC0, 9'h03F, 20};

        rst_n          = 1'b0;
        miss_valid     = 1'b0;
        miss_address   = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (3) @(negedge clk);
        chk("reset_miss_ready", LW'(miss_ready), LW'(1));
        chk("reset_busy", LW'(busy), LW'(0));
        chk("reset_req_valid", LW'(mem_req_valid), LW'(0));
        chk("reset_req_address", LW'(mem_req_address), LW'(0));
        chk("reset_write_address", LW'(write_address), LW'(0));
        chk("reset_line_data", line_data, LW'(0));
        chk("reset_write_enable", LW'(write_enable), LW'(0));
        chk("reset_refill_done", LW'(refill_done), LW'(0));
        chk("reset_state", LW'(state_dbg), LW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_refill(vecs[i].addr, vecs[i].stall, vecs[i].gap_mode, vecs[i].base, vecs[i].stray,
                      1'b0, '0, -1, vecs[i].exp_req, vecs[i].exp_idx, vecs[i].exp_lat, t0a, tda);
        end

        // Reset after beat 7, then a clean refill of line 0x40.
        do_refill(32'h0000_5000, 0, 0, 32'h7777_0000, 1'b0, 1'b0, '0, 8,
                  32'h0000_5000, 9'h140, -1, t0a, tda);
        do_refill(32'h0000_0040, 0, 0, 32'hC0DE_0000, 1'b0, 1'b0, '0, -1,
                  32'h0000_0040, 9'h001, 18, t0a, tda);

        // Back-to-back: second miss held across the first refill.
        do_refill(32'h0000_3000, 0, 0, 32'h3333_0000, 1'b1, 1'b1, 32'h0000_7FC4, -1,
                  32'h0000_3000, 9'h0C0, 18, t0a, tda);
        do_refill(32'h0000_7FC4, 0, 0, 32'h4444_0000, 1'b1, 1'b0, '0, -1,
                  32'h0000_7FC0, 9'h1FF, 18, t0b, tdb);
        chk("b2b_accept_cycle", LW'(t0b), LW'(tda + 1));

        for (int r = 0; r < 20; r++) begin
            a  = $urandom;
            st = $urandom_range(0, 3);
            do_refill(a, st, 2, $urandom, 1'($urandom_range(0, 1)), 1'b0, '0, -1,
                      model_req(a), model_idx(a), -1, t0a, tda);
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", LW'(exp_q.size()), LW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
